// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the asynchronous program-ROM read port between
// instruction fetch (IF) and data load (LS), with optional wait states and address fault checking.
module rom_port_arbiter #(
    parameter int ROM_WORDS   = 2048,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    output logic        ls_ack,
    output logic [31:0] ls_data,
    output logic        ls_err,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data
);

    localparam logic [31:0] WORD_LIMIT = 32'(ROM_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_t;

    state_t      state;
    state_t      next_state;
    grant_t      last_grant;
    grant_t      owner;
    grant_t      grant_sel;
    logic        grant_en;
    logic        tie;
    logic        capture;
    logic [31:0] grant_addr;
    logic        grant_fault;
    logic        fault;
    logic [3:0]  wait_cnt;
    logic        if_ack_next;
    logic        ls_ack_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only looked at in IDLE; RESP always falls back to IDLE so a held
    // request is arbitrated again as a fresh one.
    always_comb begin
        next_state = state;
        grant_en   = 1'b0;
        grant_sel  = GRANT_IF;
        tie        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    grant_en   = 1'b1;
                    next_state = ACCESS;
                    if (if_req && ls_req) begin
                        tie       = 1'b1;
                        grant_sel = (last_grant == GRANT_IF) ? GRANT_LS : GRANT_IF;
                    end else if (ls_req) begin
                        grant_sel = GRANT_LS;
                    end
                end
            end
            ACCESS: begin
                if (fault || (wait_cnt == 4'd0)) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_addr  = (grant_sel == GRANT_LS) ? ls_addr : if_addr;
        grant_fault = (grant_addr[1:0] != 2'b00) ||
                      ({2'b00, grant_addr[31:2]} >= WORD_LIMIT);
        if_ack_next = (next_state == RESP) && (owner == GRANT_IF);
        ls_ack_next = (next_state == RESP) && (owner == GRANT_LS);
    end

    // Address, fault flag and wait counter are latched once at grant, so later
    // address changes by the requester cannot disturb the access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= GRANT_LS;
            owner       <= GRANT_IF;
            rom_address <= 32'd0;
            wait_cnt    <= 4'd0;
            fault       <= 1'b0;
        end else if (grant_en) begin
            owner       <= grant_sel;
            rom_address <= {grant_addr[31:2], 2'b00};
            wait_cnt    <= WAIT_INIT;
            fault       <= grant_fault;
            if (tie) begin
                last_grant <= grant_sel;
            end
        end else if ((state == ACCESS) && !fault && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack  <= 1'b0;
            ls_ack  <= 1'b0;
            if_data <= 32'd0;
            ls_data <= 32'd0;
            if_err  <= 1'b0;
            ls_err  <= 1'b0;
        end else begin
            if_ack <= if_ack_next;
            ls_ack <= ls_ack_next;
            if (capture) begin
                if (owner == GRANT_IF) begin
                    if_data <= fault ? 32'd0 : rom_data;
                    if_err  <= fault;
                end else begin
                    ls_data <= fault ? 32'd0 : rom_data;
                    ls_err  <= fault;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: a zero-wait and a three-wait-state instance
// share one reset and a ROM image; expected words come from the bench's own ROM model.
module tb_rom_port_arbiter;

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, if_ack, ls_ack, if_err, ls_err;
    logic [31:0] if_addr, ls_addr, if_data, ls_data, rom_address, rom_data;
    logic        w_if_req, w_ls_req, w_if_ack, w_ls_ack, w_if_err, w_ls_err;
    logic [31:0] w_if_addr, w_ls_addr, w_if_data, w_ls_data, w_rom_address, w_rom_data;

    logic [31:0] rom [0:2047];
    exp_t        exp_q[$];
    exp_t        w_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          glitch_until = 0;
    int          if_ack_cnt = 0;
    int          ls_ack_cnt = 0;
    logic [31:0] last_if_data;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if_ack) if_ack_cnt++;
        if (ls_ack) ls_ack_cnt++;
    end

    assign rom_data   = rom[rom_address[12:2]];
    // The wait-state instance sees garbage until the cycle in which it must sample.
    assign w_rom_data = (cyc < glitch_until) ? 32'hBADC0FFE : rom[w_rom_address[12:2]];

    rom_port_arbiter #(.ROM_WORDS(2048), .WAIT_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_ack(ls_ack), .ls_data(ls_data), .ls_err(ls_err),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    rom_port_arbiter #(.ROM_WORDS(2048), .WAIT_CYCLES(3)) dut_wait (
        .clk(clk), .rst_n(rst_n),
        .if_req(w_if_req), .if_addr(w_if_addr), .if_ack(w_if_ack), .if_data(w_if_data), .if_err(w_if_err),
        .ls_req(w_ls_req), .ls_addr(w_ls_addr), .ls_ack(w_ls_ack), .ls_data(w_ls_data), .ls_err(w_ls_err),
        .rom_address(w_rom_address), .rom_data(w_rom_data)
    );

    function automatic exp_t model(input logic who, input logic [31:0] addr);
        exp_t e;
        e.who = who;
        if ((addr[1:0] != 2'b00) || (addr[31:2] >= 30'd2048)) begin
            e.data = 32'd0;
            e.err  = 1'b1;
        end else begin
            e.data = rom[addr[12:2]];
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_ack(input int max_cyc, output logic got_if, output logic got_ls, output int at);
        got_if = 1'b0;
        got_ls = 1'b0;
        at     = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (if_ack || ls_ack) begin
                got_if = if_ack;
                got_ls = ls_ack;
                at     = cyc;
                break;
            end
        end
    endtask

    task automatic w_wait_ack(input int max_cyc, output logic got, output int at);
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (w_if_ack) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({if_ack, ls_ack, if_err, ls_err} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {if_ack, ls_ack, if_err, ls_err});
        checks++;
        if ({if_data, ls_data} !== 64'd0)
            $display("[TB] FAIL reset_data: got %h/%h expected 0/0", if_data, ls_data);
        checks++;
        if (rom_address !== 32'd0)
            $display("[TB] FAIL reset_rom_address: got %h expected 0", rom_address);
        errors += ((({if_ack, ls_ack, if_err, ls_err} !== 4'b0000) ? 1 : 0) +
                   (({if_data, ls_data} !== 64'd0) ? 1 : 0) + ((rom_address !== 32'd0) ? 1 : 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_ack, ls_ack, rom_address} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got ack %b%b addr %h expected 00 addr 0", if_ack, ls_ack, rom_address);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_if();
        logic got_if, got_ls;
        int   at, start;
        exp_t e;
        if_addr = 32'h14;
        if_req  = 1'b1;
        exp_q.push_back(model(1'b0, 32'h14));
        start = cyc;
        wait_ack(10, got_if, got_ls, at);
        checks++;
        if (!(got_if && !got_ls) || at != start + 2) begin
            errors++;
            $display("[TB] FAIL single_if_timing: got if=%b ls=%b cycle %0d expected if ack cycle %0d", got_if, got_ls, at, start + 2);
        end
        if (got_if) begin
            e = exp_q.pop_front();
            checks++;
            if (if_data !== e.data || if_data !== 32'h20450123) begin
                errors++;
                $display("[TB] FAIL single_if_data: got %h expected %h", if_data, e.data);
            end
            checks++;
            if (if_err !== e.err) begin
                errors++;
                $display("[TB] FAIL single_if_err: got %b expected %b", if_err, e.err);
            end
            checks++;
            if (rom_address !== 32'h14) begin
                errors++;
                $display("[TB] FAIL single_if_rom_address: got %h expected 00000014", rom_address);
            end
        end
        exp_q.delete();
        @(posedge clk);
        #1 if_req = 1'b0;
        checks++;
        if (ls_data !== 32'd0 || ls_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_if_ls_untouched: got %h/%b expected 0/0", ls_data, ls_err);
        end
    endtask

    task automatic test_contention();
        logic got_if, got_ls;
        int   at, start;
        exp_t e;
        apply_reset();
        if_addr = 32'h100;
        ls_addr = 32'h204;
        if_req  = 1'b1;
        ls_req  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(model(1'b0, 32'h100));
            exp_q.push_back(model(1'b1, 32'h204));
        end
        start = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_ack(6, got_if, got_ls, at);
            checks++;
            if (!got_if && !got_ls) begin
                errors++;
                $display("[TB] FAIL contention_timeout: no ack for grant %0d", k);
                break;
            end
            e = exp_q.pop_front();
            if ((got_if !== !e.who) || (got_ls !== e.who) || (at != start + 2 + 3 * k)) begin
                errors++;
                $display("[TB] FAIL contention_order: grant %0d got if=%b ls=%b cycle %0d expected ls=%b cycle %0d",
                         k, got_if, got_ls, at, e.who, start + 2 + 3 * k);
            end
            checks++;
            if ((e.who ? ls_data : if_data) !== e.data) begin
                errors++;
                $display("[TB] FAIL contention_data: grant %0d got %h expected %h", k, e.who ? ls_data : if_data, e.data);
            end
        end
        exp_q.delete();
        last_if_data = rom[32'h40];
        @(posedge clk);
        #1;
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    // Consecutive LS requests, each address presented in the cycle after the previous ack.
    task automatic test_back_to_back_faults();
        logic [31:0] addrs [4];
        logic        got_if, got_ls;
        int          at, start;
        exp_t        e;
        addrs[0] = 32'h2002;
        addrs[1] = 32'h2000;
        addrs[2] = 32'h1FFC;
        addrs[3] = 32'hFFFF_FFFC;
        ls_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ls_addr = addrs[i];
            exp_q.push_back(model(1'b1, addrs[i]));
            start = cyc;
            wait_ack(6, got_if, got_ls, at);
            checks++;
            if (!(got_ls && !got_if) || at != start + 2) begin
                errors++;
                $display("[TB] FAIL fault_timing: addr %h got if=%b ls=%b cycle %0d expected ls cycle %0d",
                         addrs[i], got_if, got_ls, at, start + 2);
            end
            e = exp_q.pop_front();
            checks++;
            if (ls_data !== e.data || ls_err !== e.err) begin
                errors++;
                $display("[TB] FAIL fault_result: addr %h got %h err %b expected %h err %b", addrs[i], ls_data, ls_err, e.data, e.err);
            end
            checks++;
            if (rom_address !== {addrs[i][31:2], 2'b00} || if_data !== last_if_data) begin
                errors++;
                $display("[TB] FAIL fault_side: addr %h got rom_address %h if_data %h expected %h / %h",
                         addrs[i], rom_address, if_data, {addrs[i][31:2], 2'b00}, last_if_data);
            end
            @(posedge clk);
            #1;
        end
        ls_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_access();
        logic got_if, got_ls;
        int   at, start, cnt0;
        exp_t e;
        ls_addr = 32'h8;
        ls_req  = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        ls_req = 1'b0;
        cnt0   = ls_ack_cnt;
        @(negedge clk);
        checks++;
        if ({if_ack, ls_ack, if_err, ls_err, if_data, ls_data, rom_address} !== 100'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got ack %b%b err %b%b data %h/%h addr %h expected all 0",
                     if_ack, ls_ack, if_err, ls_err, if_data, ls_data, rom_address);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ls_ack_cnt != cnt0) begin
            errors++;
            $display("[TB] FAIL midreset_no_ack: got %0d ls acks expected 0", ls_ack_cnt - cnt0);
        end
        if_addr = 32'h20;
        ls_addr = 32'h24;
        if_req  = 1'b1;
        ls_req  = 1'b1;
        exp_q.push_back(model(1'b0, 32'h20));
        start = cyc;
        wait_ack(6, got_if, got_ls, at);
        checks++;
        if (!(got_if && !got_ls) || at != start + 2) begin
            errors++;
            $display("[TB] FAIL midreset_first_tie: got if=%b ls=%b cycle %0d expected if cycle %0d", got_if, got_ls, at, start + 2);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (if_data !== e.data || if_err !== e.err) begin
                errors++;
                $display("[TB] FAIL midreset_if_data: got %h err %b expected %h err %b", if_data, if_err, e.data, e.err);
            end
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic test_early_drop();
        logic got_if, got_ls;
        int   at, start, cnt_if;
        exp_t e;
        if_addr = 32'h30;
        if_req  = 1'b1;
        exp_q.push_back(model(1'b0, 32'h30));
        start = cyc;
        @(posedge clk);
        #1 if_req = 1'b0;
        cnt_if = if_ack_cnt;
        wait_ack(6, got_if, got_ls, at);
        checks++;
        if (!(got_if && !got_ls) || at != start + 2) begin
            errors++;
            $display("[TB] FAIL early_drop_ack: got if=%b ls=%b cycle %0d expected if cycle %0d", got_if, got_ls, at, start + 2);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (if_data !== e.data) begin
                errors++;
                $display("[TB] FAIL early_drop_data: got %h expected %h", if_data, e.data);
            end
        end
        @(posedge clk);
        #1;
        ls_addr = 32'h34;
        ls_req  = 1'b1;
        exp_q.delete();
        exp_q.push_back(model(1'b1, 32'h34));
        wait_ack(6, got_if, got_ls, at);
        checks++;
        if (!(got_ls && !got_if) || at != start + 5) begin
            errors++;
            $display("[TB] FAIL early_drop_ls: got if=%b ls=%b cycle %0d expected ls cycle %0d", got_if, got_ls, at, start + 5);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (ls_data !== e.data || ls_err !== e.err) begin
                errors++;
                $display("[TB] FAIL early_drop_ls_data: got %h err %b expected %h err %b", ls_data, ls_err, e.data, e.err);
            end
        end
        exp_q.delete();
        @(posedge clk);
        #1 ls_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if_ack_cnt != cnt_if + 1) begin
            errors++;
            $display("[TB] FAIL early_drop_single_ack: got %0d if acks expected 1", if_ack_cnt - cnt_if);
        end
    endtask

    task automatic test_wait_states();
        logic got;
        int   at, start;
        exp_t e;
        w_if_addr = 32'h0;
        w_if_req  = 1'b1;
        w_q.push_back(model(1'b0, 32'h0));
        start        = cyc;
        glitch_until = start + 4;
        w_wait_ack(12, got, at);
        checks++;
        if (!got || at != start + 5) begin
            errors++;
            $display("[TB] FAIL wait_timing: got ack=%b cycle %0d expected cycle %0d", got, at, start + 5);
        end
        e = w_q.pop_front();
        checks++;
        if (w_if_data !== e.data || w_if_data !== 32'h3401aa00 || w_if_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_data: got %h err %b expected %h err 0", w_if_data, w_if_err, e.data);
        end
        checks++;
        if ({w_ls_ack, w_ls_err, w_ls_data} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL wait_ls_untouched: got ack %b err %b data %h expected 0", w_ls_ack, w_ls_err, w_ls_data);
        end
        @(posedge clk);
        #1;
        glitch_until = 0;
        w_if_addr    = 32'h3;
        w_q.push_back(model(1'b0, 32'h3));
        start = cyc;
        w_wait_ack(12, got, at);
        checks++;
        if (!got || at != start + 2) begin
            errors++;
            $display("[TB] FAIL wait_fault_timing: got ack=%b cycle %0d expected cycle %0d", got, at, start + 2);
        end
        e = w_q.pop_front();
        checks++;
        if (w_if_data !== e.data || w_if_err !== e.err) begin
            errors++;
            $display("[TB] FAIL wait_fault_result: got %h err %b expected %h err %b", w_if_data, w_if_err, e.data, e.err);
        end
        @(posedge clk);
        #1 w_if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = (32'h9E3779B9 * 32'(i)) ^ 32'h00005A5A;
        rom[0] = 32'h3401aa00;
        rom[5] = 32'h20450123;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        ls_req    = 1'b0;
        if_addr   = 32'd0;
        ls_addr   = 32'd0;
        w_if_req  = 1'b0;
        w_ls_req  = 1'b0;
        w_if_addr = 32'd0;
        w_ls_addr = 32'd0;
        last_if_data = 32'd0;

        test_reset();
        test_single_if();
        test_contention();
        test_back_to_back_faults();
        test_reset_mid_access();
        test_early_drop();
        test_wait_states();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
